b01_serial_sched: RTL
=====================

Name: b01_serial_sched

Overview:
Two-requester round-robin scheduler for the b01 serial datapath. It accepts parallel operand pairs from two clients and clears the serial unit before each job. It then shifts the operands LSB-first onto LINE1/LINE2, collects the per-bit OUTP_REG stream and the OVERFLW_REG flag, and returns a parallel result with a done pulse. It sits between the block-level clients and a single shared serial unit instance.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
LAT, 1, cycles from a LINE1/LINE2 bit being driven to its OUTP_REG bit being valid (>=1)

Ports:
clock  in  1  system clock, all state on rising edge
RESET_G  in  1  synchronous active-high reset
req0  in  1  client 0 job request, held until gnt0
a0  in  WIDTH  client 0 operand A
b0  in  WIDTH  client 0 operand B
req1  in  1  client 1 job request, held until gnt1
a1  in  WIDTH  client 1 operand A
b1  in  WIDTH  client 1 operand B
gnt0  out  1  one-cycle pulse: client 0 job accepted, operands latched
gnt1  out  1  one-cycle pulse: client 1 job accepted, operands latched
LINE1  out  1  serial bit of A to the unit
LINE2  out  1  serial bit of B to the unit
unit_rst  out  1  reset to the serial unit
OUTP_REG  in  1  serial result bit from the unit
OVERFLW_REG  in  1  overflow flag from the unit
res  out  WIDTH  collected result, LSB = first captured bit
ovf  out  1  OR of OVERFLW_REG over the capture window
done  out  1  one-cycle pulse: res/ovf/done_id valid
done_id  out  1  client that owns the completed job
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (RESET_G high at an edge): state IDLE, RR pointer favours client 0. gnt0/gnt1/LINE1/LINE2/done/busy = 0. res = 0, ovf = 0, done_id = 0.
- unit_rst = RESET_G OR (state == CLR), combinational.
- FSM states: IDLE -> CLR -> SHIFT (WIDTH cycles) -> DRAIN (LAT cycles) -> DONE (1 cycle) -> IDLE.
- IDLE arbitration:
  - Only one request high: that client wins.
  - Both high: the client not served last wins. After reset, client 0 wins.
  - The winner's operands and id are latched at the edge that leaves IDLE.
- CLR cycle: gnt of the winner = 1, unit_rst = 1, LINE1/LINE2 = 0. Capture registers are cleared (shift reg = 0, ovf accumulator = 0).
- SHIFT cycle k (k = 0..WIDTH-1): LINE1 = A[k], LINE2 = B[k].
- Capture window: the WIDTH cycles starting LAT cycles after SHIFT k=0. In each window cycle, OUTP_REG is shifted in MSB-side (right shift), so bit k lands in res[k]. OVERFLW_REG is ORed into the accumulator. Samples outside the window are ignored.
- DRAIN: LINE1/LINE2 = 0. Capture continues to the end of the window. The window ends on the last DRAIN cycle.
- DONE: done = 1 for exactly one cycle. res, ovf and done_id update at the edge entering DONE and hold until the next DONE or reset. The RR pointer records done_id.
- Job latency: from the edge sampling req in IDLE to the done cycle = WIDTH + LAT + 2 cycles. There is at least one IDLE cycle between jobs.
- Requests are ignored outside IDLE. A req dropped before gnt is withdrawn with no side effect.
- Reset mid-job: abort immediately. No done, no gnt, pointer reset. The unit is held in reset via unit_rst.
- Operand changes after gnt have no effect on the running job.

Test Plan:
- Bench unit model OUTP = LINE1^LINE2 delayed LAT; WIDTH=8, LAT=1. req0 with a0=0xA5, b0=0x0F -> gnt0 in cycle 1, done in cycle 11, res=0xAA, ovf=0, done_id=0.
- req0 and req1 both high from reset, each held until its gnt -> gnt0 first, done_id=0. One IDLE cycle later gnt1, done_id=1. No overlap of busy jobs.
- req1 alone (a1=0xFF, b1=0x00 -> res=0xFF), then req0 and req1 together -> gnt0 wins. Then a further double request -> gnt1 wins.
- Model pulses OVERFLW_REG at capture bit 5 -> ovf=1. Repeat with the pulse only during the CLR cycle -> ovf=0.
- RESET_G asserted for 1 cycle at SHIFT k=3 -> next cycle busy=0, LINE1=LINE2=0, unit_rst=1 during reset. No done. The following req0 is served normally with the correct result.
- LAT=3 build, a0=0x3C, b0=0x3C -> res=0x00, done in cycle 13. LINE1/LINE2=0 throughout the 3 DRAIN cycles.

Source files
------------

// File: rtl/b01_serial_sched.sv
// Two-client round-robin scheduler feeding a shared b01 serial unit: latches an
// operand pair, clears the unit, shifts A/B out LSB-first and gathers the serial result.
module b01_serial_sched #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic             clock,
  input  logic             RESET_G,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             LINE1,
  output logic             LINE2,
  output logic             unit_rst,
  input  logic             OUTP_REG,
  input  logic             OVERFLW_REG,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             done,
  output logic             done_id,
  output logic             busy,
  output logic [2:0]       o_dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CW = $clog2(WIDTH + LAT + 1);
  localparam logic [CW-1:0] TICK_SHIFT_END = CW'(WIDTH - 1);
  localparam logic [CW-1:0] TICK_END       = CW'(WIDTH + LAT - 1);
  localparam logic [CW-1:0] TICK_CAP       = CW'(LAT);

  logic [2:0]       r_state;
  logic             r_last_id;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_tick;
  logic [WIDTH-1:0] r_sh;
  logic             r_acc;
  logic [WIDTH-1:0] r_res;
  logic             r_ovf;
  logic             r_done_id;

  logic             w_pick1;
  logic             w_any;
  logic             w_cap;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_acc_next;

  // r_last_id holds the client served last; on a tie the other one wins.
  assign w_any      = req0 | req1;
  assign w_pick1    = req1 & (~req0 | ~r_last_id);
  // r_tick counts from SHIFT k=0; the capture window is ticks LAT..WIDTH+LAT-1.
  assign w_cap      = (r_tick >= TICK_CAP);
  assign w_sh_next  = {OUTP_REG, r_sh[WIDTH-1:1]};
  assign w_acc_next = r_acc | OVERFLW_REG;

  always_ff @(posedge clock) begin
    if (RESET_G) begin
      r_state   <= S_IDLE;
      r_last_id <= 1'b1;
      r_id      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_tick    <= '0;
      r_sh      <= '0;
      r_acc     <= 1'b0;
      r_res     <= '0;
      r_ovf     <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id    <= w_pick1;
            r_a     <= w_pick1 ? a1 : a0;
            r_b     <= w_pick1 ? b1 : b0;
            r_state <= S_CLR;
          end
        end
        S_CLR: begin
          r_sh    <= '0;
          r_acc   <= 1'b0;
          r_tick  <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_tick <= r_tick + CW'(1);
          if (w_cap) begin
            r_sh  <= w_sh_next;
            r_acc <= w_acc_next;
          end
          if (r_tick == TICK_SHIFT_END) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_tick <= r_tick + CW'(1);
          if (w_cap) begin
            r_sh  <= w_sh_next;
            r_acc <= w_acc_next;
          end
          // Last window sample is folded straight into the result registers.
          if (r_tick == TICK_END) begin
            r_res     <= w_sh_next;
            r_ovf     <= w_acc_next;
            r_done_id <= r_id;
            r_last_id <= r_id;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0        = (r_state == S_CLR) & ~r_id;
  assign gnt1        = (r_state == S_CLR) &  r_id;
  assign LINE1       = (r_state == S_SHIFT) & r_a[0];
  assign LINE2       = (r_state == S_SHIFT) & r_b[0];
  assign unit_rst    = RESET_G | (r_state == S_CLR);
  assign done        = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign res         = r_res;
  assign ovf         = r_ovf;
  assign done_id     = r_done_id;
  assign o_dbg_state = r_state;

endmodule
